formic_bctl_trace_pack: RTL and testbench
=========================================

// Module: formic_bctl_trace_pack
// PURPOSE
//  Downstream consumer of the board-controller trace input FIFO. Dequeues
//  8-byte trace records, packs each into one 64-bit word with a drop tag and
//  writes it into a circular trace buffer through a req/ack write port.
//  Also keeps a saturating count of records the upstream stage discarded.
// PARAMETERS
//  AW        10  word-address width of trace buffer
//  DCNT_W    16  width of drop counter (saturates at all-ones)
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  i_data        in   8      FIFO head byte
//  i_data_valid  in   1      FIFO head byte valid
//  o_deq         out  1      consume i_data this cycle
//  i_drop        in   1      upstream dropped >=1 record since last deq
//  i_enable      in   1      allow new records to start
//  i_buf_last    in   AW     last word address of circular buffer
//  o_wr_req      out  1      write request (held until ack)
//  o_wr_adr      out  AW     word address
//  o_wr_data     out  64     packed word
//  i_wr_ack      in   1      write accepted this cycle
//  o_wr_ptr      out  AW     next address to be written
//  o_wrapped     out  1      sticky: buffer wrapped at least once
//  o_drop_cnt    out  DCNT_W dropped-record events seen
// BEHAVIOUR
//  Reset: o_deq=0, o_wr_req=0, o_wr_adr=0, o_wr_data=0, o_wr_ptr=0,
//   o_wrapped=0, o_drop_cnt=0, FSM=IdleSt, byte count=0.
//  o_deq = (State==CollSt) & i_data_valid; byte taken in same cycle.
//  FSM (one-hot): IdleSt -> CollSt when i_enable; CollSt -> WrSt after
//   8th byte deq'd; WrSt -> TsSt on i_wr_ack if TRACE_TSTAMP_EN, else
//   -> IdleSt; TsSt -> IdleSt on i_wr_ack.
//  Packing: byte k (0..7) of record -> o_wr_data[63-8k -: 8]; byte 0 MSB.
//   Drop tag: no spare bits; tag goes to o_drop_cnt only (see below).
//  Drop: i_drop sampled on deq of byte 0; if 1, o_drop_cnt+1 (saturating,
//   holds at all-ones); i_drop elsewhere ignored.
//  Write: o_wr_req=1 from entry into WrSt/TsSt until cycle of i_wr_ack;
//   o_wr_adr/o_wr_data stable while req high. On ack o_wr_ptr advances:
//   ptr==i_buf_last -> 0 and o_wrapped<=1, else ptr+1. o_wr_adr=o_wr_ptr.
//  i_enable low: checked only in IdleSt; record in progress always completes.
//  i_data_valid low mid-record: stall in CollSt, byte count held.
//  i_buf_last changed at runtime: ptr>i_buf_last wraps to 0 on next ack.
//  Reset mid-record: partial record discarded, no write issued.
//  Latency: o_wr_req rises 1 cycle after 8th deq.
// CONFIGURATION
//  TRACE_TSTAMP_EN defined: 32-bit free-running cycle counter; value latched
//   at byte-0 deq; second word {tstamp[31:0], drop_cnt zero-ext to 32}
//   written after record word (2 buffer words/record).
//  Undefined: no counter, no TsSt, 1 word/record.
// STRUCTURE
//  Shared package: FSM state encodings, RECORD_BYTES=8, word width 64.
//  Sub-module: formic_bctl_trace_wrptr (circular pointer + wrapped flag).
// TESTING
//  1) 8 bytes 0x01..0x08 back-to-back, ack immediate -> one write,
//     adr 0, data 0x0102030405060708, o_wr_ptr=1.
//  2) i_data_valid gaps after byte 3 -> deq stalls, same data word written.
//  3) i_buf_last=3, 5 records -> adrs 0,1,2,3,0; o_wrapped=1 after 4th ack.
//  4) i_drop=1 on byte 0 of 3 records -> o_drop_cnt=3; DCNT_W=2, 5 drops ->3.
//  5) i_wr_ack delayed 10 cycles -> req/adr/data held, no deq meanwhile.
//  6) rst after byte 5 -> no write; next record lands at adr 0.

Source files
------------

// File: rtl/formic_bctl_trace_pack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : formic_bctl_trace_pack_pkg                                      |
// | Purpose  : Shared FSM encodings, record geometry and packing helper.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package formic_bctl_trace_pack_pkg;

    localparam int RECORD_BYTES = 8;
    localparam int WORD_W       = 64;
    localparam int TSTAMP_W     = 32;
    localparam int BCNT_W       = 3;

    typedef enum logic [3:0] {
        IdleSt = 4'b0001,
        CollSt = 4'b0010,
        WrSt   = 4'b0100,
        TsSt   = 4'b1000
    } state_t;

    // Byte 0 of a record lands in the most significant byte of the word.
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word,
        input logic [BCNT_W-1:0] idx,
        input logic [7:0]        b
    );
        logic [WORD_W-1:0] w_word;
        w_word = word;
        w_word[WORD_W-1-8*int'(idx) -: 8] = b;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/formic_bctl_trace_wrptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : formic_bctl_trace_wrptr                                         |
// | Purpose  : Circular trace-buffer write pointer with sticky wrapped flag.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module formic_bctl_trace_wrptr #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    input  logic [AW-1:0] i_last,
    output logic [AW-1:0] o_ptr,
    output logic          o_wrapped
);

    logic [AW-1:0] r_ptr;
    logic          r_wrapped;

    // >= so a pointer stranded beyond a shrunken buffer end returns to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (i_adv) begin
            if (r_ptr >= i_last) begin
                r_ptr     <= '0;
                r_wrapped <= 1'b1;
            end else begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

    assign o_ptr     = r_ptr;
    assign o_wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: rtl/formic_bctl_trace_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : formic_bctl_trace_pack                                          |
// | Purpose  : Packs 8-byte trace records into 64-bit circular-buffer writes   |
// |            and counts upstream drops. Define TRACE_TSTAMP_EN to append a   |
// |            {timestamp, drop count} word after each record.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module formic_bctl_trace_pack
    import formic_bctl_trace_pack_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_data,
    input  logic              i_data_valid,
    output logic              o_deq,
    input  logic              i_drop,
    input  logic              i_enable,
    input  logic [AW-1:0]     i_buf_last,
    output logic              o_wr_req,
    output logic [AW-1:0]     o_wr_adr,
    output logic [63:0]       o_wr_data,
    input  logic              i_wr_ack,
    output logic [AW-1:0]     o_wr_ptr,
    output logic              o_wrapped,
    output logic [DCNT_W-1:0] o_drop_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [WORD_W-1:0]   r_rec;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_wr_req;
    logic [DCNT_W-1:0]   r_drop_cnt;
    logic                w_deq;
    logic                w_ack;
    logic                w_first_byte;

    assign w_deq        = (r_state == CollSt) & i_data_valid;
    assign w_ack        = r_wr_req & i_wr_ack;
    assign w_first_byte = w_deq & (r_byte_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IdleSt: if (i_enable) w_next_state = CollSt;
            CollSt: if (w_deq && r_byte_cnt == BCNT_W'(RECORD_BYTES-1)) w_next_state = WrSt;
`ifdef TRACE_TSTAMP_EN
            WrSt:   if (w_ack) w_next_state = TsSt;
`else
            WrSt:   if (w_ack) w_next_state = IdleSt;
`endif
            TsSt:   if (w_ack) w_next_state = IdleSt;
            default: w_next_state = IdleSt;
        endcase
    end

`ifdef TRACE_TSTAMP_EN
    logic [TSTAMP_W-1:0] r_tstamp;
    logic [TSTAMP_W-1:0] r_tstamp_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tstamp     <= '0;
            r_tstamp_lat <= '0;
        end else begin
            r_tstamp <= r_tstamp + TSTAMP_W'(1);
            if (w_first_byte) r_tstamp_lat <= r_tstamp;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IdleSt;
            r_byte_cnt <= '0;
            r_rec      <= '0;
            r_wr_data  <= '0;
            r_wr_req   <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_wr_req <= (w_next_state == WrSt) || (w_next_state == TsSt);
            if (w_deq) begin
                r_rec      <= insert_byte(r_rec, r_byte_cnt, i_data);
                r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
            if (w_first_byte && i_drop && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + DCNT_W'(1);
            // Output word is frozen here so it stays stable for the whole request.
            if (r_state == CollSt && w_next_state == WrSt)
                r_wr_data <= insert_byte(r_rec, r_byte_cnt, i_data);
`ifdef TRACE_TSTAMP_EN
            if (r_state == WrSt && w_next_state == TsSt)
                r_wr_data <= {r_tstamp_lat, 32'(r_drop_cnt)};
`endif
        end
    end

    formic_bctl_trace_wrptr #(
        .AW (AW)
    ) u_wrptr (
        .clk       (clk),
        .rst       (rst),
        .i_adv     (w_ack),
        .i_last    (i_buf_last),
        .o_ptr     (o_wr_ptr),
        .o_wrapped (o_wrapped)
    );

    assign o_deq      = w_deq;
    assign o_wr_req   = r_wr_req;
    assign o_wr_adr   = o_wr_ptr;
    assign o_wr_data  = r_wr_data;
    assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_formic_bctl_trace_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_formic_bctl_trace_pack                                       |
// | Purpose  : Directed self-checking bench for formic_bctl_trace_pack.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_formic_bctl_trace_pack;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    i_data;
    logic          i_data_valid;
    logic          i_drop;
    logic          i_enable;
    logic [AW-1:0] i_buf_last;
    logic          i_wr_ack;

    logic          o_deq, o_wr_req, o_wrapped;
    logic [AW-1:0] o_wr_adr, o_wr_ptr;
    logic [63:0]   o_wr_data;
    logic [15:0]   o_drop_cnt;

    logic          s_deq, s_wr_req, s_wrapped;
    logic [AW-1:0] s_wr_adr, s_wr_ptr;
    logic [63:0]   s_wr_data;
    logic [1:0]    s_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    formic_bctl_trace_pack #(.AW(AW), .DCNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_deq(o_deq), .i_drop(i_drop), .i_enable(i_enable), .i_buf_last(i_buf_last),
        .o_wr_req(o_wr_req), .o_wr_adr(o_wr_adr), .o_wr_data(o_wr_data),
        .i_wr_ack(i_wr_ack), .o_wr_ptr(o_wr_ptr), .o_wrapped(o_wrapped),
        .o_drop_cnt(o_drop_cnt)
    );

    // Narrow drop counter instance for the saturation case.
    formic_bctl_trace_pack #(.AW(AW), .DCNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_deq(s_deq), .i_drop(i_drop), .i_enable(i_enable), .i_buf_last(i_buf_last),
        .o_wr_req(s_wr_req), .o_wr_adr(s_wr_adr), .o_wr_data(s_wr_data),
        .i_wr_ack(i_wr_ack), .o_wr_ptr(s_wr_ptr), .o_wrapped(s_wrapped),
        .o_drop_cnt(s_drop_cnt)
    );

    task automatic do_reset();
        rst = 1'b1; i_data = 8'h00; i_data_valid = 1'b0; i_drop = 1'b0; i_wr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic d);
        int n;
        n = 0;
        i_data = b; i_data_valid = 1'b1; i_drop = d;
        #1;
        while (o_deq !== 1'b1 && n < 50) begin
            @(posedge clk); #2; n++;
        end
        checks++;
        if (o_deq !== 1'b1) begin
            errors++;
            $display("FAIL deq_timeout: o_deq=%b required 1 for byte %h", o_deq, b);
        end
        @(posedge clk); #1;
        i_data_valid = 1'b0; i_drop = 1'b0;
    endtask

    task automatic send_record(input logic [63:0] w, input logic [7:0] dmask,
                               input int gap_at, input int gap_len);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b = w[63-8*k -: 8];
            put_byte(b, dmask[k]);
            if (k == gap_at) begin
                i_data_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (o_deq !== 1'b0 || o_wr_req !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_stall: deq=%b req=%b required 0 0", o_deq, o_wr_req);
                    end
                end
            end
        end
    endtask

    task automatic wait_write(input logic [AW-1:0] ea, input logic [63:0] ed, input int delay);
        int n;
        n = 0;
        while (o_wr_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (o_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_req_timeout: o_wr_req=%b required 1", o_wr_req);
        end
        checks++;
        if (o_wr_adr !== ea) begin
            errors++;
            $display("FAIL wr_adr: got %0d required %0d", o_wr_adr, ea);
        end
        checks++;
        if (o_wr_data !== ed) begin
            errors++;
            $display("FAIL wr_data: got %h required %h", o_wr_data, ed);
        end
        i_data = 8'hEE; i_data_valid = 1'b1;
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
            checks++;
            if (o_wr_req !== 1'b1 || o_wr_adr !== ea || o_wr_data !== ed || o_deq !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold: req=%b adr=%0d data=%h deq=%b required 1 %0d %h 0",
                         o_wr_req, o_wr_adr, o_wr_data, o_deq, ea, ed);
            end
        end
        i_wr_ack = 1'b1;
        @(posedge clk); #1;
        i_wr_ack = 1'b0; i_data_valid = 1'b0;
        checks++;
        if (o_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_req_drop: o_wr_req=%b required 0 after ack", o_wr_req);
        end
    endtask

    task automatic test_reset();
        i_enable = 1'b0; i_buf_last = 10'd1023;
        do_reset();
        checks++;
        if (o_deq !== 1'b0 || o_wr_req !== 1'b0 || o_wr_adr !== '0 || o_wr_data !== 64'h0 ||
            o_wr_ptr !== '0 || o_wrapped !== 1'b0 || o_drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: deq=%b req=%b adr=%0d data=%h ptr=%0d wrap=%b drop=%0d required all 0",
                     o_deq, o_wr_req, o_wr_adr, o_wr_data, o_wr_ptr, o_wrapped, o_drop_cnt);
        end
        i_data_valid = 1'b1; i_data = 8'h55;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_deq !== 1'b0) begin
                errors++;
                $display("FAIL enable_low: o_deq=%b required 0", o_deq);
            end
        end
        i_data_valid = 1'b0;
        i_enable = 1'b1;
    endtask

    task automatic test_basic();
        send_record(64'h0102030405060708, 8'h00, -1, 0);
        checks++;
        if (o_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL req_latency: o_wr_req=%b required 1 one cycle after 8th deq", o_wr_req);
        end
        wait_write(10'd0, 64'h0102030405060708, 0);
        checks++;
        if (o_wr_ptr !== 10'd1) begin
            errors++;
            $display("FAIL ptr_after_first: got %0d required 1", o_wr_ptr);
        end
    endtask

    task automatic test_back_to_back();
        send_record(64'hF0E1D2C3B4A59687, 8'h00, -1, 0);
        wait_write(10'd1, 64'hF0E1D2C3B4A59687, 0);
        checks++;
        if (o_wr_ptr !== 10'd2 || o_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_state: ptr=%0d drop=%0d required 2 0", o_wr_ptr, o_drop_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        send_record(64'h0102030405060708, 8'h00, 3, 4);
        wait_write(10'd0, 64'h0102030405060708, 0);
    endtask

    task automatic test_wrap();
        logic [63:0] w;
        i_buf_last = 10'd3;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            w = 64'hC0C1C2C3C4C5C600 | 64'(k);
            send_record(w, 8'h00, -1, 0);
            wait_write(10'(k % 4), w, 0);
            checks++;
            if (o_wrapped !== (k >= 3) || o_wr_ptr !== 10'((k + 1) % 4)) begin
                errors++;
                $display("FAIL wrap_rec%0d: wrapped=%b ptr=%0d required %b %0d",
                         k, o_wrapped, o_wr_ptr, (k >= 3), (k + 1) % 4);
            end
        end
        i_buf_last = 10'd1023;
    endtask

    task automatic test_drop();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_record(64'hA0A1A2A3A4A5A6A7, 8'h01, -1, 0);
            wait_write(10'(k), 64'hA0A1A2A3A4A5A6A7, 0);
        end
        checks++;
        if (o_drop_cnt !== 16'd3 || s_drop_cnt !== 2'd3) begin
            errors++;
            $display("FAIL drop_three: cnt=%0d small=%0d required 3 3", o_drop_cnt, s_drop_cnt);
        end
        send_record(64'hB0B1B2B3B4B5B6B7, 8'hFE, -1, 0);
        wait_write(10'd3, 64'hB0B1B2B3B4B5B6B7, 0);
        checks++;
        if (o_drop_cnt !== 16'd3 || s_drop_cnt !== 2'd3) begin
            errors++;
            $display("FAIL drop_ignored: cnt=%0d small=%0d required 3 3", o_drop_cnt, s_drop_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            send_record(64'hD0D1D2D3D4D5D6D7, 8'h01, -1, 0);
            wait_write(10'(4 + k), 64'hD0D1D2D3D4D5D6D7, 0);
        end
        checks++;
        if (o_drop_cnt !== 16'd5) begin
            errors++;
            $display("FAIL drop_five: cnt=%0d required 5", o_drop_cnt);
        end
        checks++;
        if (s_drop_cnt !== 2'd3) begin
            errors++;
            $display("FAIL drop_saturate: small=%0d required 3", s_drop_cnt);
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        send_record(64'h1122334455667788, 8'h00, -1, 0);
        wait_write(10'd0, 64'h1122334455667788, 10);
        checks++;
        if (o_wr_ptr !== 10'd1) begin
            errors++;
            $display("FAIL ack_delay_ptr: got %0d required 1", o_wr_ptr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_record(64'h0, 8'h00, -1, 0);
        wait_write(10'd0, 64'h0, 0);
        for (int k = 0; k < 5; k++) put_byte(8'h90 + 8'(k), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_wr_req !== 1'b0 || o_wr_ptr !== '0) begin
                errors++;
                $display("FAIL reset_mid_nowrite: req=%b ptr=%0d required 0 0", o_wr_req, o_wr_ptr);
            end
        end
        send_record(64'h2122232425262728, 8'h00, -1, 0);
        wait_write(10'd0, 64'h2122232425262728, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_drop();
        test_ack_delay();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
